fetch_du_stage: RTL and testbench

Parametrised MIPS instruction-fetch stage with a debug-unit (DU) program-load port, a run/step/halt controller, and halt-instruction detection. It holds the PC, an asynchronous-read instruction memory writable by the DU, and the IF/ID pipeline register with a valid bit. It sits between the DU and the decode stage and replaces the fixed, read-only fetch stage for debug-controlled execution.

---
 rtl/fetch_du_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_du_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_du_stage.sv
// MIPS instruction-fetch stage with a debug-unit loadable instruction memory,
// a run/step/halt controller, halt-word detection and an IF/ID register with valid bit.
module fetch_du_stage #(
  parameter int unsigned        NB_BITS    = 32,
  parameter int unsigned        RAM_DEPTH  = 10,
  parameter string              INIT_FILE  = "",
  parameter logic [NB_BITS-1:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [NB_BITS-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_du_we,
  input  logic [RAM_DEPTH-1:0] i_du_addr,
  input  logic [NB_BITS-1:0]   i_du_data,
  input  logic                 i_du_run,
  input  logic                 i_du_step,
  input  logic                 i_du_restart,
  input  logic [NB_BITS-1:0]   i_brq_addr,
  input  logic [NB_BITS-1:0]   i_jmp_addr,
  input  logic                 i_ctr_beq,
  input  logic                 i_ctr_jmp,
  input  logic                 i_ctr_flush,
  input  logic                 i_pc_we,
  input  logic                 i_if_id_we,
  output logic [NB_BITS-1:0]   o_pc,
  output logic [NB_BITS-1:0]   o_if_id_pc,
  output logic [NB_BITS-1:0]   o_if_id_instr,
  output logic                 o_if_id_valid,
  output logic                 o_halt,
  output logic [1:0]           o_state,
  output logic [NB_BITS-1:0]   o_fetch_count
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10,
    StHalt = 2'b11
  } state_e;

  logic [NB_BITS-1:0]   r_mem [2**RAM_DEPTH];
  state_e               r_state;
  logic [NB_BITS-1:0]   r_pc;
  logic [NB_BITS-1:0]   r_if_id_pc;
  logic [NB_BITS-1:0]   r_if_id_instr;
  logic                 r_if_id_valid;
  logic [NB_BITS-1:0]   r_fetch_count;

  logic                 w_active;
  logic                 w_fetch;
  logic                 w_halt_det;
  logic [RAM_DEPTH-1:0] w_index;
  logic [NB_BITS-1:0]   w_word;
  logic [NB_BITS-1:0]   w_pc_plus4;
  logic [NB_BITS-1:0]   w_pc_next;
  logic [NB_BITS-1:0]   w_tgt_mask;

  assign w_active   = (r_state == StRun) || (r_state == StStep);
  assign w_index    = r_pc[RAM_DEPTH+1:2];
  assign w_word     = r_mem[w_index];
  assign w_pc_plus4 = r_pc + NB_BITS'(4);
  assign w_tgt_mask = {{(NB_BITS-2){1'b1}}, 2'b00};
  assign w_fetch    = w_active && i_if_id_we;
  // A flushed shadow fetch can never halt the machine.
  assign w_halt_det = w_fetch && !i_ctr_flush && (w_word == HALT_INSTR);

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (i_ctr_jmp) begin
      w_pc_next = i_jmp_addr & w_tgt_mask;
    end else if (i_ctr_beq) begin
      w_pc_next = i_brq_addr & w_tgt_mask;
    end
  end

  // The DU may only rewrite the program while the core is not fetching.
  always_ff @(posedge i_clk) begin
    if (i_du_we && !w_active) begin
      r_mem[i_du_addr] <= i_du_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_du_restart) begin
      r_state       <= StIdle;
      r_pc          <= '0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      if (w_active && i_pc_we && !w_halt_det) begin
        r_pc <= w_pc_next;
      end

      if (w_fetch) begin
        if (i_ctr_flush) begin
          r_if_id_instr <= NOP_INSTR;
          r_if_id_valid <= 1'b0;
          r_if_id_pc    <= w_pc_plus4;
        end else if (w_halt_det) begin
          r_if_id_instr <= NOP_INSTR;
          r_if_id_valid <= 1'b0;
        end else begin
          r_if_id_instr <= w_word;
          r_if_id_valid <= 1'b1;
          r_if_id_pc    <= w_pc_plus4;
          r_fetch_count <= r_fetch_count + NB_BITS'(1);
        end
      end

      unique case (r_state)
        StIdle: begin
          if (i_du_run) begin
            r_state <= StRun;
          end else if (i_du_step) begin
            r_state <= StStep;
          end
        end
        StRun: begin
          if (w_halt_det) r_state <= StHalt;
        end
        StStep: begin
          // A step completes on the first cycle the pipeline actually advances.
          if (i_pc_we && i_if_id_we) begin
            r_state <= w_halt_det ? StHalt : StIdle;
          end
        end
        StHalt: r_state <= StHalt;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_if_id_pc    = r_if_id_pc;
  assign o_if_id_instr = r_if_id_instr;
  assign o_if_id_valid = r_if_id_valid;
  assign o_fetch_count = r_fetch_count;
  assign o_state       = r_state;
  assign o_halt        = (r_state == StHalt);

endmodule

// File: tb/tb_fetch_du_stage.sv
// Bench for fetch_du_stage: directed vector table, hand sequences for branch/halt/restart
// corners, then randomized traffic checked against a spec-level model.
module tb_fetch_du_stage;
  localparam int          RD   = 10;
  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] W0   = 32'h2001_0001;
  localparam logic [31:0] W1   = 32'h2002_0002;
  localparam logic [31:0] W2   = 32'h2003_0003;
  localparam logic [1:0]  SI = 2'd0, SR = 2'd1, SS = 2'd2, SH = 2'd3;

  logic clk = 1'b0;
  logic rst, du_we, du_run, du_step, du_restart, beq, jmp, flush, pc_we, ifid_we;
  logic [RD-1:0] du_addr;
  logic [31:0] du_data, brq, jmp_addr;
  logic [31:0] o_pc, o_if_id_pc, o_if_id_instr, o_fetch_count;
  logic o_if_id_valid, o_halt;
  logic [1:0] o_state;

  fetch_du_stage dut (
    .i_clk(clk), .i_rst(rst), .i_du_we(du_we), .i_du_addr(du_addr), .i_du_data(du_data),
    .i_du_run(du_run), .i_du_step(du_step), .i_du_restart(du_restart),
    .i_brq_addr(brq), .i_jmp_addr(jmp_addr), .i_ctr_beq(beq), .i_ctr_jmp(jmp),
    .i_ctr_flush(flush), .i_pc_we(pc_we), .i_if_id_we(ifid_we),
    .o_pc(o_pc), .o_if_id_pc(o_if_id_pc), .o_if_id_instr(o_if_id_instr),
    .o_if_id_valid(o_if_id_valid), .o_halt(o_halt), .o_state(o_state),
    .o_fetch_count(o_fetch_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_st(input string n, input logic [31:0] pc, input logic [31:0] ifpc,
                          input logic [31:0] instr, input logic valid, input logic [1:0] st,
                          input logic [31:0] cnt);
    check({n, ".pc"}, o_pc, pc);
    check({n, ".ifpc"}, o_if_id_pc, ifpc);
    check({n, ".instr"}, o_if_id_instr, instr);
    check({n, ".valid"}, o_if_id_valid, valid);
    check({n, ".state"}, o_state, st);
    check({n, ".halt"}, o_halt, st == SH);
    check({n, ".count"}, o_fetch_count, cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    rst = 0; du_we = 0; du_addr = '0; du_data = '0; du_run = 0; du_step = 0; du_restart = 0;
    beq = 0; jmp = 0; brq = '0; jmp_addr = '0; flush = 0; pc_we = 1; ifid_we = 1;
  endtask

  task automatic du_write(input logic [RD-1:0] a, input logic [31:0] d);
    du_we = 1; du_addr = a; du_data = d;
    tick();
    du_we = 0;
  endtask

  task automatic pulse_restart();
    du_restart = 1;
    tick();
    du_restart = 0;
  endtask

  typedef struct {
    logic run, step, restart, pc_we, ifid_we;
    logic [31:0] pc, ifpc, instr;
    logic valid;
    logic [1:0] st;
    logic [31:0] cnt;
  } vec_t;
  vec_t tbl[19];

  // Spec-level reference model
  logic [31:0] m_mem [1024];
  logic [31:0] m_pc, m_ifpc, m_instr, m_count;
  logic m_valid;
  logic [1:0] m_state;

  task automatic model_step();
    logic [31:0] word, p4;
    logic act, fetch, hdet, wr;
    act   = (m_state == SR) || (m_state == SS);
    word  = m_mem[m_pc[11:2]];
    p4    = m_pc + 32'd4;
    fetch = act && ifid_we;
    hdet  = fetch && !flush && (word == HALT);
    wr    = du_we && !act;
    if (du_restart) begin
      m_state = SI; m_pc = 0; m_ifpc = 0; m_instr = NOP; m_valid = 0; m_count = 0;
    end else begin
      if (fetch) begin
        if (flush) begin
          m_instr = NOP; m_valid = 0; m_ifpc = p4;
        end else if (hdet) begin
          m_instr = NOP; m_valid = 0;
        end else begin
          m_instr = word; m_valid = 1; m_ifpc = p4; m_count = m_count + 1;
        end
      end
      case (m_state)
        SI: if (du_run) m_state = SR; else if (du_step) m_state = SS;
        SR: if (hdet) m_state = SH;
        SS: if (pc_we && ifid_we) m_state = hdet ? SH : SI;
        default: ;
      endcase
      if (act && pc_we && !hdet)
        m_pc = jmp ? (jmp_addr & ~32'd3) : beq ? (brq & ~32'd3) : p4;
    end
    if (wr) m_mem[du_addr] = du_data;
  endtask

  initial begin
    //             run stp rs pwe iwe  pc     ifpc   instr v  st  cnt
    tbl[0]  = '{1, 0, 0, 1, 1, 32'h0, 32'h0, NOP, 0, SR, 0};
    tbl[1]  = '{0, 0, 0, 1, 1, 32'h4, 32'h4, W0,  1, SR, 1};
    tbl[2]  = '{0, 0, 0, 1, 1, 32'h8, 32'h8, W1,  1, SR, 2};
    tbl[3]  = '{0, 0, 0, 1, 1, 32'hC, 32'hC, W2,  1, SR, 3};
    tbl[4]  = '{0, 0, 0, 1, 1, 32'hC, 32'hC, NOP, 0, SH, 3};
    tbl[5]  = '{1, 0, 0, 1, 1, 32'hC, 32'hC, NOP, 0, SH, 3};
    tbl[6]  = '{0, 1, 0, 1, 1, 32'hC, 32'hC, NOP, 0, SH, 3};
    tbl[7]  = '{0, 0, 1, 1, 1, 32'h0, 32'h0, NOP, 0, SI, 0};
    tbl[8]  = '{0, 1, 0, 1, 1, 32'h0, 32'h0, NOP, 0, SS, 0};
    tbl[9]  = '{0, 0, 0, 1, 1, 32'h4, 32'h4, W0,  1, SI, 1};
    tbl[10] = '{0, 1, 0, 1, 1, 32'h4, 32'h4, W0,  1, SS, 1};
    tbl[11] = '{0, 0, 0, 1, 1, 32'h8, 32'h8, W1,  1, SI, 2};
    tbl[12] = '{0, 1, 0, 1, 1, 32'h8, 32'h8, W1,  1, SS, 2};
    tbl[13] = '{0, 0, 0, 1, 1, 32'hC, 32'hC, W2,  1, SI, 3};
    tbl[14] = '{1, 0, 0, 1, 1, 32'hC, 32'hC, W2,  1, SR, 3};
    tbl[15] = '{0, 0, 0, 0, 0, 32'hC, 32'hC, W2,  1, SR, 3};
    tbl[16] = '{0, 0, 0, 0, 0, 32'hC, 32'hC, W2,  1, SR, 3};
    tbl[17] = '{0, 0, 0, 1, 1, 32'hC, 32'hC, NOP, 0, SH, 3};
    tbl[18] = '{0, 0, 1, 1, 1, 32'h0, 32'h0, NOP, 0, SI, 0};

    defaults();
    rst = 1;
    tick();
    check_st("reset", 32'h0, 32'h0, NOP, 0, SI, 0);
    tick();
    rst = 0;

    du_write(10'd0, W0);
    du_write(10'd1, W1);
    du_write(10'd2, W2);
    du_write(10'd3, HALT);

    for (int i = 0; i < 19; i++) begin
      du_run = tbl[i].run; du_step = tbl[i].step; du_restart = tbl[i].restart;
      pc_we = tbl[i].pc_we; ifid_we = tbl[i].ifid_we;
      tick();
      check_st($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].ifpc, tbl[i].instr, tbl[i].valid,
               tbl[i].st, tbl[i].cnt);
    end
    defaults();

    // DU write together with run: first fetch sees the new word; writes in RUN are dropped
    du_we = 1; du_addr = 10'd0; du_data = 32'hABCD_0001; du_run = 1;
    tick();
    defaults();
    check_st("wrrun", 32'h0, 32'h0, NOP, 0, SR, 0);
    tick();
    check_st("wrrun_f", 32'h4, 32'h4, 32'hABCD_0001, 1, SR, 1);
    du_we = 1; du_addr = 10'd0; du_data = 32'hDEAD_BEEF;
    tick();
    defaults();
    pulse_restart();
    du_run = 1;
    tick();
    du_run = 0;
    tick();
    check_st("norw", 32'h4, 32'h4, 32'hABCD_0001, 1, SR, 1);

    // Jump beats branch; HALT in a flushed shadow is ignored
    pulse_restart();
    du_write(10'd0, HALT);
    du_write(10'd16, 32'h1111_1111);
    du_write(10'd17, HALT);
    du_write(10'd32, 32'h2222_2222);
    du_write(10'd33, HALT);
    du_run = 1;
    tick();
    du_run = 0;
    jmp = 1; beq = 1; jmp_addr = 32'h41; brq = 32'h80; flush = 1;
    tick();
    defaults();
    check_st("jmp", 32'h40, 32'h4, NOP, 0, SR, 0);
    tick();
    check_st("jmp_f", 32'h44, 32'h44, 32'h1111_1111, 1, SR, 1);
    tick();
    check_st("halt", 32'h44, 32'h44, NOP, 0, SH, 1);
    pulse_restart();
    check_st("rs_halt", 32'h0, 32'h0, NOP, 0, SI, 0);
    du_run = 1;
    tick();
    du_run = 0;
    beq = 1; brq = 32'h83; flush = 1;
    tick();
    defaults();
    check_st("beq", 32'h80, 32'h4, NOP, 0, SR, 0);
    tick();
    check_st("beq_f", 32'h84, 32'h84, 32'h2222_2222, 1, SR, 1);
    tick();
    check_st("halt2", 32'h84, 32'h84, NOP, 0, SH, 1);

    // Randomized traffic against the model
    pulse_restart();
    for (int a = 0; a < 1024; a++) begin
      logic [31:0] d;
      d = $urandom;
      if (d == HALT) d = 32'h0;
      m_mem[a] = d;
      du_write(RD'(a), d);
    end
    m_state = SI; m_pc = 0; m_ifpc = 0; m_instr = NOP; m_valid = 0; m_count = 0;
    for (int c = 0; c < 1500; c++) begin
      du_we      = ($urandom % 5) == 0;
      du_addr    = RD'($urandom % 16);
      du_data    = (($urandom % 6) == 0) ? HALT : $urandom;
      du_run     = ($urandom % 4) == 0;
      du_step    = ($urandom % 4) == 0;
      du_restart = (m_state == SH) ? (($urandom % 3) == 0) : (($urandom % 40) == 0);
      beq        = ($urandom % 8) == 0;
      jmp        = ($urandom % 8) == 0;
      brq        = $urandom % 128;
      jmp_addr   = $urandom % 128;
      flush      = ($urandom % 4) == 0;
      pc_we      = ($urandom % 7) != 0;
      ifid_we    = ($urandom % 7) != 0;
      model_step();
      tick();
      check($sformatf("rand%0d", c),
            {o_pc, o_if_id_pc, o_if_id_instr, o_fetch_count, o_if_id_valid, o_state, o_halt},
            {m_pc, m_ifpc, m_instr, m_count, m_valid, m_state, m_state == SH});
    end
    defaults();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
